seq_feeder: RTL and testbench
=============================

# seq_feeder

Upstream feeder for the 2-bit base shift register of the alignment accelerator. Accepts 32-bit words of four ASCII nucleotide characters over a valid/ready stream, encodes each to 2 bits (A=00, C=01, G=10, T=11, case-insensitive), and drives the shift register's `in`/`en`/`dir` inputs one base per cycle, gapless when input is sustained. Tracks bases emitted, flags when the B-base window is full, and reports invalid characters.

## Interface
- `B`, 4: window length in bases; must match the downstream shift register.
- `CNT_W`, 16: width of the emitted-base counter.
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a sequence; sampled only in IDLE.
- `dir_cfg`  in  1  shift direction; latched at start.
- `hold`  in  1  stall emission; buffer frozen.
- `s_valid`  in  1  input word valid.
- `s_ready`  out  1  input word accepted when `s_valid && s_ready` at an edge.
- `s_data`  in  32  four ASCII chars; byte 0 (bits 7:0) is emitted first.
- `s_last`  in  1  final word of the sequence.
- `s_cnt`  in  2  valid chars minus one in the final word; ignored unless `s_last`.
- `base`  out  2  encoded base to the shift register `in`.
- `en`  out  1  base valid / shift enable.
- `dir`  out  1  latched `dir_cfg`.
- `window_full`  out  1  high once at least B bases have been emitted.
- `bases_emitted`  out  CNT_W  bases emitted since start; saturates at all-ones.
- `err`  out  1  sticky: a non-ACGT character was seen.
- `done`  out  1  one-cycle pulse at sequence end.

## Operation
- States: IDLE -> RUN on `start`; RUN -> DRAIN on accepting the `s_last` word; DRAIN -> DONE when remaining reaches 0; DONE -> IDLE unconditionally.
- On `start`: latch `dir`; clear `bases_emitted`, `window_full`, `err`.
- Buffer holds one word plus `rem` (0..4 unemitted chars).
- `s_ready` = RUN && (`rem`==0 || (`rem`==1 && !`hold`)).
- Emit edge (`rem`>0 && !`hold`): `base` <= enc(next char), `en` <= 1, `rem` decrements, counter increments. Otherwise `en` <= 0 and `base` holds.
- Accept edge with `rem`==1: emit the old last char and load the new word (`rem` <= 4, or `s_cnt`+1 if `s_last`) on the same edge.
- Invalid char: `base` = 00, still emitted with `en`=1, `err` set.
- `start` outside IDLE is ignored. `s_valid` in IDLE/DRAIN/DONE is not accepted.

## Timing
- Reset values: state IDLE; `s_ready`, `base`, `en`, `dir`, `window_full`, `bases_emitted`, `err`, `done` all 0; `rem`=0.
- Latency: word accepted at edge k gives byte 0 on `base` with `en`=1 after edge k+1.
- Sustained input: one base per cycle, no bubbles; `s_ready` high one cycle in four.
- `window_full` rises the cycle after the B-th `en` cycle.
- `done` asserts the cycle after the final `en`, for one cycle.
- Reset mid-operation: all outputs return to reset values immediately; the partial sequence is discarded.

## Configuration
- `SEQ_FEEDER_N_MASK_EN` defined: adds output `n_mask` (1 bit, reset 0). `n_mask` is high alongside `en` when the char is N/n; such chars emit base 00 and do not set `err`.
- Not defined: no `n_mask` port; N/n is invalid and sets `err`.

## Structure
- `seq_pkg`: base encoding constants (BASE_A/C/G/T), ASCII codes, FSM state enum.
- Sub-module `base_enc`: combinational ASCII-to-2-bit encoder with `valid` and `is_n` outputs; instantiated once on the selected buffer byte.

## Test plan
- "ACGT" (0x54474341), `s_last`, `s_cnt`=3 -> `en` 4 cycles with bases 00,01,10,11; `window_full`=1 after the 4th; `done` pulse next cycle; `bases_emitted`=4.
- Two words with `s_valid` held high -> 8 consecutive `en` cycles, no gap; `s_ready` high once per 4 cycles.
- `hold` high for 3 cycles after the 2nd base -> `en`=0 for those 3 cycles; base order unchanged; `s_ready` low throughout.
- "acgx" -> bases 00,01,10,00 and `err`=1; next `start` clears `err` to 0.
- Final word "GT.." with `s_cnt`=1 -> exactly 2 bases (10,11), then `done`.
- `reset` asserted mid-RUN -> all outputs 0 at once; `s_ready`=0; `start` is needed to resume.

Source files
------------

// File: rtl/seq_pkg.sv
// seq_pkg: base encodings, ASCII codes and FSM states shared by seq_feeder and base_enc.
package seq_pkg;

    localparam logic [1:0] BASE_A = 2'b00;
    localparam logic [1:0] BASE_C = 2'b01;
    localparam logic [1:0] BASE_G = 2'b10;
    localparam logic [1:0] BASE_T = 2'b11;

    localparam logic [7:0] ASCII_A = 8'h41;
    localparam logic [7:0] ASCII_C = 8'h43;
    localparam logic [7:0] ASCII_G = 8'h47;
    localparam logic [7:0] ASCII_T = 8'h54;
    localparam logic [7:0] ASCII_N = 8'h4E;

    localparam logic [7:0] ASCII_LOWER_A = 8'h61;
    localparam logic [7:0] ASCII_LOWER_Z = 8'h7A;
    localparam logic [7:0] ASCII_CASE_BIT = 8'h20;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Folds lowercase letters onto uppercase; all other codes pass through.
    function automatic logic [7:0] to_upper(input logic [7:0] c);
        if (c >= ASCII_LOWER_A && c <= ASCII_LOWER_Z)
            return c & ~ASCII_CASE_BIT;
        return c;
    endfunction

endpackage

// File: rtl/base_enc.sv
// base_enc: combinational ASCII nucleotide to 2-bit base encoder, case-insensitive.
// Unrecognised characters give code 00 with valid low; is_n flags N/n.
module base_enc
    import seq_pkg::*;
(
    input  logic [7:0] ch,
    output logic [1:0] code,
    output logic       valid,
    output logic       is_n
);

    logic [7:0] up;

    always_comb begin
        up    = to_upper(ch);
        code  = BASE_A;
        valid = 1'b1;
        is_n  = (up == ASCII_N);
        case (up)
            ASCII_A: code = BASE_A;
            ASCII_C: code = BASE_C;
            ASCII_G: code = BASE_G;
            ASCII_T: code = BASE_T;
            default: begin
                code  = BASE_A;
                valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/seq_feeder.sv
// seq_feeder: accepts 4-char ASCII words and feeds the base shift register one base per cycle.
// Build option SEQ_FEEDER_N_MASK_EN adds n_mask and lets N/n through as a masked base.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | accepting words, emitting bases
// DRAIN | final word accepted, emitting what is left of it
// DONE  | end of sequence, done pulses for this one cycle
module seq_feeder
    import seq_pkg::*;
#(
    parameter int B     = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             dir_cfg,
    input  logic             hold,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [31:0]      s_data,
    input  logic             s_last,
    input  logic [1:0]       s_cnt,
    output logic [1:0]       base,
    output logic             en,
    output logic             dir,
    output logic             window_full,
    output logic [CNT_W-1:0] bases_emitted,
    output logic             err,
    output logic             done
`ifdef SEQ_FEEDER_N_MASK_EN
    ,
    output logic             n_mask
`endif
);

    localparam logic [CNT_W-1:0] B_CNT   = CNT_W'(B);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t      state, state_nx;
    logic [31:0] word_q;
    logic [2:0]  rem;
    logic [1:0]  idx;
    logic [7:0]  cur_char;
    logic [1:0]  enc_code;
    logic        enc_valid;
    logic        enc_is_n;
    logic        char_bad;
    logic        emit;
    logic        accept;

    assign s_ready  = (state == ST_RUN) && ((rem == 3'd0) || ((rem == 3'd1) && !hold));
    assign accept   = s_valid && s_ready;
    assign emit     = (rem != 3'd0) && !hold;
    assign cur_char = word_q[{idx, 3'b000} +: 8];

    base_enc u_base_enc (
        .ch    (cur_char),
        .code  (enc_code),
        .valid (enc_valid),
        .is_n  (enc_is_n)
    );

`ifdef SEQ_FEEDER_N_MASK_EN
    assign char_bad = !enc_valid && !enc_is_n;
`else
    // N is already outside the valid set; named here so both builds read alike.
    assign char_bad = !enc_valid || enc_is_n;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (start) state_nx = ST_RUN;
            ST_RUN:   if (accept && s_last) state_nx = ST_DRAIN;
            ST_DRAIN: if (rem == 3'd0) state_nx = ST_DONE;
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_q        <= '0;
            rem           <= '0;
            idx           <= '0;
            base          <= BASE_A;
            en            <= 1'b0;
            dir           <= 1'b0;
            window_full   <= 1'b0;
            bases_emitted <= '0;
            err           <= 1'b0;
            done          <= 1'b0;
`ifdef SEQ_FEEDER_N_MASK_EN
            n_mask        <= 1'b0;
`endif
        end else begin
            en   <= 1'b0;
            done <= (state_nx == ST_DONE);
`ifdef SEQ_FEEDER_N_MASK_EN
            n_mask <= 1'b0;
`endif

            if (state == ST_IDLE && start) begin
                dir           <= dir_cfg;
                bases_emitted <= '0;
                window_full   <= 1'b0;
                err           <= 1'b0;
            end else if (state != ST_IDLE) begin
                window_full <= window_full || (bases_emitted >= B_CNT);
            end

            if (emit) begin
                base <= enc_code;
                en   <= 1'b1;
                rem  <= rem - 3'd1;
                idx  <= idx + 2'd1;
                if (bases_emitted != CNT_MAX)
                    bases_emitted <= bases_emitted + CNT_W'(1);
                if (char_bad)
                    err <= 1'b1;
`ifdef SEQ_FEEDER_N_MASK_EN
                n_mask <= enc_is_n;
`endif
            end

            // A load on the rem==1 edge overrides the emit's rem/idx update.
            if (accept) begin
                word_q <= s_data;
                idx    <= 2'd0;
                rem    <= s_last ? ({1'b0, s_cnt} + 3'd1) : 3'd4;
            end
        end
    end

endmodule

// File: tb/tb_seq_feeder.sv
// tb_seq_feeder: randomized self-checking bench for seq_feeder against a character-stream model.
module tb_seq_feeder;

    localparam int B      = 4;
    localparam int CNT_W  = 5;
    localparam int BUDGET = 400;

    localparam logic [7:0] GOOD [8] = '{8'h41, 8'h43, 8'h47, 8'h54, 8'h61, 8'h63, 8'h67, 8'h74};
    localparam logic [7:0] BAD  [4] = '{8'h4E, 8'h6E, 8'h78, 8'h2E};

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             dir_cfg;
    logic             hold;
    logic             s_valid;
    logic             s_ready;
    logic [31:0]      s_data;
    logic             s_last;
    logic [1:0]       s_cnt;
    logic [1:0]       base;
    logic             en;
    logic             dir;
    logic             window_full;
    logic [CNT_W-1:0] bases_emitted;
    logic             err;
    logic             done;
`ifdef SEQ_FEEDER_N_MASK_EN
    logic             n_mask;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_chars [$];
    int         obs_base [$];
    int         obs_en_cyc [$];
    int         obs_done_cyc [$];
    int         acc_cyc [$];
    bit         obs_nm [$];
    int         wf_cyc;
    int         ready_hi;
    int         ready_in_hold;
    bit         timed_out;

    seq_feeder #(.B(B), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .dir_cfg       (dir_cfg),
        .hold          (hold),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .s_last        (s_last),
        .s_cnt         (s_cnt),
        .base          (base),
        .en            (en),
        .dir           (dir),
        .window_full   (window_full),
        .bases_emitted (bases_emitted),
        .err           (err),
        .done          (done)
`ifdef SEQ_FEEDER_N_MASK_EN
        ,
        .n_mask        (n_mask)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int ref_base(input logic [7:0] c);
        case (c)
            8'h41, 8'h61: return 0;
            8'h43, 8'h63: return 1;
            8'h47, 8'h67: return 2;
            8'h54, 8'h74: return 3;
            default:      return 0;
        endcase
    endfunction

    function automatic bit ref_is_n(input logic [7:0] c);
        return (c == 8'h4E) || (c == 8'h6E);
    endfunction

    function automatic bit ref_bad(input logic [7:0] c);
        bit good;
        good = (c == 8'h41) || (c == 8'h61) || (c == 8'h43) || (c == 8'h63) ||
               (c == 8'h47) || (c == 8'h67) || (c == 8'h54) || (c == 8'h74);
`ifdef SEQ_FEEDER_N_MASK_EN
        if (ref_is_n(c)) return 1'b0;
`endif
        return !good;
    endfunction

    function automatic bit ref_seq_err();
        bit e = 1'b0;
        foreach (exp_chars[i]) e |= ref_bad(exp_chars[i]);
        return e;
    endfunction

    function automatic int ref_count();
        int lim = (1 << CNT_W) - 1;
        return (exp_chars.size() > lim) ? lim : exp_chars.size();
    endfunction

    function automatic logic [7:0] rand_char(input int bad_pct);
        if ($urandom_range(99) < bad_pct) return BAD[$urandom_range(3)];
        return GOOD[$urandom_range(7)];
    endfunction

    function automatic logic [31:0] pack_word(input int wi);
        logic [31:0] w;
        for (int j = 0; j < 4; j++) begin
            if (wi * 4 + j < exp_chars.size()) w[j*8 +: 8] = exp_chars[wi * 4 + j];
            else                               w[j*8 +: 8] = 8'h2E;
        end
        return w;
    endfunction

    task automatic set_chars(input logic [31:0] w, input int n);
        exp_chars.delete();
        for (int j = 0; j < n; j++) exp_chars.push_back(w[j*8 +: 8]);
    endtask

    task automatic idle_inputs();
        start = 0; dir_cfg = 0; hold = 0; s_valid = 0; s_data = '0; s_last = 0; s_cnt = '0;
    endtask

    // Drives exp_chars as a word stream and records what the DUT emits, cycle by cycle.
    task automatic run_seq(input bit do_start, input bit dir_v, input int hold_pct, input int gap_pct,
                           input int hold_after, input int hold_len);
        int  nw, wi, cyc, hold_left, en_seen, post;
        bit  hold_used;
        nw = (exp_chars.size() + 3) / 4;
        obs_base.delete(); obs_en_cyc.delete(); obs_done_cyc.delete(); acc_cyc.delete(); obs_nm.delete();
        wf_cyc = -1; ready_hi = 0; ready_in_hold = 0; timed_out = 0;
        wi = 0; cyc = 0; hold_left = 0; en_seen = 0; post = -1; hold_used = 0;
        @(negedge clk);
        if (do_start) begin start = 1; dir_cfg = dir_v; end
        forever begin
            @(negedge clk);
            cyc++;
            start = 0;
            if (en) begin
                obs_base.push_back(int'(base));
                obs_en_cyc.push_back(cyc);
                en_seen++;
`ifdef SEQ_FEEDER_N_MASK_EN
                obs_nm.push_back(n_mask);
`endif
            end
            if (done) obs_done_cyc.push_back(cyc);
            if (window_full && wf_cyc < 0) wf_cyc = cyc;
            if (post >= 0) begin
                post--;
                if (post == 0) break;
            end else if (done) begin
                post = 2;
            end
            if (cyc > BUDGET) begin timed_out = 1; break; end
            if (hold_after > 0 && en_seen == hold_after && !hold_used) begin
                hold_left = hold_len; hold_used = 1;
            end
            if (hold_left > 0) begin hold = 1; hold_left--; end
            else hold = ($urandom_range(99) < hold_pct);
            if (wi < nw && $urandom_range(99) >= gap_pct) begin
                s_valid = 1;
                s_data  = pack_word(wi);
                s_last  = (wi == nw - 1);
                s_cnt   = (wi == nw - 1) ? 2'((exp_chars.size() - 1) % 4) : 2'($urandom);
            end else begin
                s_valid = 0; s_data = $urandom; s_last = 1'($urandom); s_cnt = 2'($urandom);
            end
            #1;
            if (s_ready) begin
                ready_hi++;
                if (hold) ready_in_hold++;
            end
            if (s_valid && s_ready) begin acc_cyc.push_back(cyc); wi++; end
        end
        s_valid = 0; hold = 0; s_last = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_inputs();
        reset = 1;
        repeat (2) @(negedge clk);
        checks++;
        if ({s_ready, base, en, dir, window_full, err, done} !== 8'b0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b base=%b en=%b dir=%b wf=%b err=%b done=%b required all 0",
                     s_ready, base, en, dir, window_full, err, done);
        end
        checks++;
        if (bases_emitted !== '0) begin
            errors++; $display("FAIL reset_count: got %0d required 0", bases_emitted);
        end
        reset = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (s_ready !== 1'b0 || en !== 1'b0) begin
            errors++; $display("FAIL idle_quiet: got rdy=%b en=%b required 0 0", s_ready, en);
        end
    endtask

    task automatic test_acgt();
        set_chars(32'h54474341, 4);
        run_seq(1, 1, 0, 0, 0, 0);
        checks++;
        if (timed_out) begin errors++; $display("FAIL acgt_timeout: no done within %0d cycles", BUDGET); end
        checks++;
        if (obs_base.size() != 4) begin
            errors++; $display("FAIL acgt_en_count: got %0d required 4", obs_base.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (obs_base[i] != i) begin
                    errors++; $display("FAIL acgt_base[%0d]: got %0d required %0d", i, obs_base[i], i);
                end
            end
            checks++;
            if (acc_cyc.size() < 1 || obs_en_cyc[0] != acc_cyc[0] + 2) begin
                errors++; $display("FAIL acgt_latency: first en cycle %0d, required accept+2", obs_en_cyc[0]);
            end
            checks++;
            if (obs_en_cyc[3] != obs_en_cyc[0] + 3) begin
                errors++; $display("FAIL acgt_gapless: span %0d required 3", obs_en_cyc[3] - obs_en_cyc[0]);
            end
            checks++;
            if (wf_cyc != obs_en_cyc[3] + 1) begin
                errors++; $display("FAIL acgt_window_full: rose at %0d required %0d", wf_cyc, obs_en_cyc[3] + 1);
            end
            checks++;
            if (obs_done_cyc.size() != 1 || obs_done_cyc[0] != obs_en_cyc[3] + 1) begin
                errors++; $display("FAIL acgt_done: %0d pulses, first at %0d, required 1 at %0d",
                                   obs_done_cyc.size(), (obs_done_cyc.size() > 0) ? obs_done_cyc[0] : -1,
                                   obs_en_cyc[3] + 1);
            end
        end
        checks++;
        if (bases_emitted !== CNT_W'(4) || err !== 1'b0 || dir !== 1'b1) begin
            errors++; $display("FAIL acgt_status: got cnt=%0d err=%b dir=%b required 4 0 1", bases_emitted, err, dir);
        end
    endtask

    task automatic test_back_to_back();
        exp_chars.delete();
        repeat (8) exp_chars.push_back(rand_char(0));
        run_seq(1, 0, 0, 0, 0, 0);
        checks++;
        if (timed_out || obs_base.size() != 8) begin
            errors++; $display("FAIL b2b_count: got %0d bases timeout=%b required 8", obs_base.size(), timed_out);
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (obs_base[i] != ref_base(exp_chars[i])) begin
                    errors++; $display("FAIL b2b_base[%0d]: got %0d required %0d", i, obs_base[i], ref_base(exp_chars[i]));
                end
            end
            checks++;
            if (obs_en_cyc[7] != obs_en_cyc[0] + 7) begin
                errors++; $display("FAIL b2b_gapless: span %0d required 7", obs_en_cyc[7] - obs_en_cyc[0]);
            end
        end
        checks++;
        if (acc_cyc.size() != 2 || ready_hi != 2 || acc_cyc[1] - acc_cyc[0] != 4) begin
            errors++; $display("FAIL b2b_ready: %0d accepts, %0d ready cycles, required 2 accepts 4 apart",
                               acc_cyc.size(), ready_hi);
        end
    endtask

    task automatic test_hold();
        exp_chars.delete();
        repeat (8) exp_chars.push_back(rand_char(0));
        run_seq(1, 1, 0, 0, 2, 3);
        checks++;
        if (timed_out || obs_base.size() != 8) begin
            errors++; $display("FAIL hold_count: got %0d bases timeout=%b required 8", obs_base.size(), timed_out);
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (obs_base[i] != ref_base(exp_chars[i])) begin
                    errors++; $display("FAIL hold_base[%0d]: got %0d required %0d", i, obs_base[i], ref_base(exp_chars[i]));
                end
            end
            checks++;
            if (obs_en_cyc[1] != obs_en_cyc[0] + 1 || obs_en_cyc[2] != obs_en_cyc[1] + 4 ||
                obs_en_cyc[7] != obs_en_cyc[2] + 5) begin
                errors++; $display("FAIL hold_gap: en cycles %0d %0d %0d .. %0d required one 3-cycle gap after base 2",
                                   obs_en_cyc[0], obs_en_cyc[1], obs_en_cyc[2], obs_en_cyc[7]);
            end
        end
        checks++;
        if (ready_in_hold != 0) begin
            errors++; $display("FAIL hold_ready: s_ready high %0d cycles during hold required 0", ready_in_hold);
        end
    endtask

    task automatic test_invalid();
        set_chars(32'h78676361, 4);
        run_seq(1, 0, 0, 0, 0, 0);
        checks++;
        if (obs_base.size() != 4) begin
            errors++; $display("FAIL inval_count: got %0d required 4", obs_base.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (obs_base[i] != ref_base(exp_chars[i])) begin
                    errors++; $display("FAIL inval_base[%0d]: got %0d required %0d", i, obs_base[i], ref_base(exp_chars[i]));
                end
            end
        end
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL inval_err: got %b required 1", err); end
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        checks++;
        if (err !== 1'b0 || bases_emitted !== '0) begin
            errors++; $display("FAIL start_clears: got err=%b cnt=%0d required 0 0", err, bases_emitted);
        end
        set_chars(32'h54545454, 4);
        run_seq(0, 0, 0, 0, 0, 0);
        checks++;
        if (timed_out || obs_base.size() != 4 || err !== 1'b0) begin
            errors++; $display("FAIL after_clear: got %0d bases err=%b required 4 0", obs_base.size(), err);
        end
    endtask

    task automatic test_partial();
        set_chars(32'h2E2E5447, 2);
        run_seq(1, 0, 0, 0, 0, 0);
        checks++;
        if (obs_base.size() != 2) begin
            errors++; $display("FAIL partial_count: got %0d required 2", obs_base.size());
        end else begin
            checks++;
            if (obs_base[0] != 2 || obs_base[1] != 3) begin
                errors++; $display("FAIL partial_bases: got %0d %0d required 2 3", obs_base[0], obs_base[1]);
            end
            checks++;
            if (obs_done_cyc.size() != 1 || obs_done_cyc[0] != obs_en_cyc[1] + 1) begin
                errors++; $display("FAIL partial_done: %0d pulses required 1 right after last base", obs_done_cyc.size());
            end
        end
        checks++;
        if (err !== 1'b0 || window_full !== 1'b0 || bases_emitted !== CNT_W'(2)) begin
            errors++; $display("FAIL partial_status: got err=%b wf=%b cnt=%0d required 0 0 2", err, window_full, bases_emitted);
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        int cyc = 0;
        int bad = 0;
        exp_chars.delete();
        repeat (4) exp_chars.push_back(rand_char(0));
        @(negedge clk);
        start = 1; dir_cfg = 1;
        @(negedge clk);
        start = 0; s_valid = 1; s_data = pack_word(0); s_last = 0;
        while (seen < 2 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (en) seen++;
        end
        checks++;
        if (seen < 2) begin errors++; $display("FAIL midreset_setup: saw %0d bases required 2", seen); end
        #1 reset = 1;
        #1;
        checks++;
        if ({s_ready, base, en, dir, window_full, err, done} !== 8'b0 || bases_emitted !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got rdy=%b base=%b en=%b dir=%b wf=%b err=%b done=%b cnt=%0d required all 0",
                     s_ready, base, en, dir, window_full, err, done, bases_emitted);
        end
        @(negedge clk);
        reset = 0;
        repeat (6) begin
            @(negedge clk);
            #1;
            if (en !== 1'b0 || s_ready !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL midreset_needs_start: %0d active cycles required 0", bad); end
        idle_inputs();
    endtask

    task automatic test_random();
        for (int it = 0; it < 12; it++) begin
            int n  = $urandom_range(14, 1);
            bit d  = 1'($urandom);
            int hp = $urandom_range(40);
            int gp = $urandom_range(40);
            int nb;
            exp_chars.delete();
            repeat (n) exp_chars.push_back(rand_char(10));
            run_seq(1, d, hp, gp, 0, 0);
            checks++;
            if (timed_out || obs_base.size() != n) begin
                errors++; $display("FAIL rand%0d_count: got %0d bases timeout=%b required %0d", it, obs_base.size(), timed_out, n);
            end
            nb = (obs_base.size() < n) ? obs_base.size() : n;
            for (int i = 0; i < nb; i++) begin
                checks++;
                if (obs_base[i] != ref_base(exp_chars[i])) begin
                    errors++; $display("FAIL rand%0d_base[%0d]: got %0d required %0d", it, i, obs_base[i], ref_base(exp_chars[i]));
                end
`ifdef SEQ_FEEDER_N_MASK_EN
                checks++;
                if (obs_nm[i] != ref_is_n(exp_chars[i])) begin
                    errors++; $display("FAIL rand%0d_nmask[%0d]: got %b required %b", it, i, obs_nm[i], ref_is_n(exp_chars[i]));
                end
`endif
            end
            checks++;
            if (err !== ref_seq_err() || bases_emitted !== CNT_W'(ref_count()) || dir !== d) begin
                errors++; $display("FAIL rand%0d_status: got err=%b cnt=%0d dir=%b required %b %0d %b",
                                   it, err, bases_emitted, dir, ref_seq_err(), ref_count(), d);
            end
            if (nb == n) begin
                checks++;
                if (obs_done_cyc.size() != 1 || obs_done_cyc[0] != obs_en_cyc[n-1] + 1) begin
                    errors++; $display("FAIL rand%0d_done: %0d pulses required 1 right after last base", it, obs_done_cyc.size());
                end
                checks++;
                if ((n >= B) ? (wf_cyc != obs_en_cyc[B-1] + 1) : (wf_cyc != -1)) begin
                    errors++; $display("FAIL rand%0d_window_full: rose at %0d required %0d", it, wf_cyc,
                                       (n >= B) ? obs_en_cyc[B-1] + 1 : -1);
                end
            end
        end
    endtask

    task automatic test_saturate();
        exp_chars.delete();
        repeat (36) exp_chars.push_back(rand_char(0));
        run_seq(1, 0, 0, 0, 0, 0);
        checks++;
        if (timed_out || obs_base.size() != 36) begin
            errors++; $display("FAIL sat_count: got %0d bases required 36", obs_base.size());
        end
        checks++;
        if (bases_emitted !== CNT_W'(ref_count()) || window_full !== 1'b1) begin
            errors++; $display("FAIL sat_counter: got cnt=%0d wf=%b required %0d 1", bases_emitted, window_full, ref_count());
        end
    endtask

    initial begin
        test_reset();
        test_acgt();
        test_back_to_back();
        test_hold();
        test_invalid();
        test_partial();
        test_reset_mid();
        test_random();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
